sc_fib_sequencer: RTL
=====================

// Module: sc_fib_sequencer
// PURPOSE
// - Control+operand stage feeding the Fibonacci datapath's general-purpose result register.
// - On a start strobe, generates terms F0..F(N-1) of the Fibonacci sequence.
// - For each term it drives the term value plus active-low clear/load strobes for the downstream register.
// - Flags done and overflow when the run finishes or a term is truncated.
// PARAMETERS
// - FibSEQ_DATAWIDTH  8  width of emitted term and internal operands A/B
// - FibSEQ_CNTWIDTH   5  width of requested term count N and internal index k
// PORTS
// - SC_FibSEQ_CLOCK_50      in   1          single system clock, rising edge
// - SC_FibSEQ_RESET_InHigh  in   1          asynchronous, active-high reset
// - SC_FibSEQ_start_InLow   in   1          active-low start request, sampled in IDLE only
// - SC_FibSEQ_count_InBUS   in   CNTWIDTH   N = number of terms, latched with start
// - SC_FibSEQ_data_OutBUS   out  DATAWIDTH  current term (A register) for downstream data input
// - SC_FibSEQ_clear_OutLow  out  1          0 for exactly one cycle (CLEAR) to clear downstream register
// - SC_FibSEQ_load_OutLow   out  1          0 during each EMIT cycle; downstream loads data_OutBUS
// - SC_FibSEQ_busy_Out      out  1          1 in every state except IDLE
// - SC_FibSEQ_done_Out      out  1          1 for exactly one cycle (DONE)
// - SC_FibSEQ_overflow_Out  out  1          sticky per run: some emitted term exceeded 2^DATAWIDTH-1
// BEHAVIOUR
// - Reset values: state=IDLE, A=0, B=1, k=0, Nreg=0, ovf bits=0.
// - Reset outputs: data=0, clear=1, load=1, busy=0, done=0, overflow=0.
// - Reset is honoured at any time, including mid-run; it aborts the run immediately with no done pulse.
// - Moore FSM; all strobes are decoded from registered state, so there are no combinational paths from inputs to outputs.
// - IDLE -> CLEAR when start_InLow==0 at a clock edge.
//   - On that edge: latch Nreg=count, A=0, B=1, k=0, clear overflow and ovf bits.
// - CLEAR: clear_OutLow=0.
//   - Next state is EMIT if Nreg!=0, else DONE.
// - EMIT: load_OutLow=0, data=A.
//   - If A_ovf, overflow<=1.
//   - If k==Nreg-1 -> DONE; else k<=k+1 and -> STEP.
// - STEP: {carry,sum}=A+B at DATAWIDTH+1 bits.
//   - A<=B, A_ovf<=B_ovf; B<=sum[DATAWIDTH-1:0], B_ovf<=B_ovf|A_ovf|carry.
//   - Next state is EMIT.
// - DONE: done_Out=1 -> IDLE.
//   - data_OutBUS holds last term; overflow holds until the next accepted start.
// - Timing, with cycle 0 = the cycle start is sampled:
//   - CLEAR in cycle 1.
//   - EMIT in cycles 2,4,...,2N.
//   - DONE in cycle 2N+1; IDLE in cycle 2N+2.
//   - N=0: CLEAR in cycle 1, DONE in cycle 2, no load strobes.
// - start_InLow is ignored while busy.
// - If start_InLow is held low, a new run begins from the IDLE cycle after DONE (one IDLE cycle minimum between runs).
// - count_InBUS changes after the start edge have no effect on the current run.
// - Arithmetic wraps modulo 2^DATAWIDTH; after overflow the run continues to completion with truncated values.
// - Unused state encodings -> IDLE.
// STRUCTURE
// - Shared package/header holds:
//   - state localparams IDLE/CLEAR/EMIT/STEP/DONE (3-bit encoding);
//   - default widths FibSEQ_DATAWIDTH, FibSEQ_CNTWIDTH.
// - One natural sub-module: sc_fib_operand_pair.
//   - Contains A/B registers, ovf bits, and the DATAWIDTH+1 adder.
//   - Controls: init, step (both active-high).
//   - Outputs: A, A_ovf.
// - Top level holds the FSM, k counter, Nreg latch, sticky overflow, and output decode.
// TESTING
// - N=8, W=8, start low 1 cycle:
//   - clear low in cycle 1;
//   - load low in cycles 2,4,..,16 with data 0,1,1,2,3,5,8,13;
//   - done=1 in cycle 17; overflow=0.
// - N=0: clear low in cycle 1, no load strobe, done in cycle 2, busy high in cycles 1-2 only.
// - N=15, W=8:
//   - emits F12=144 and F13=233 with overflow=0;
//   - the EMIT of F14 shows data=121 (377 mod 256) and overflow rises that cycle;
//   - overflow stays high through DONE.
//   - A following run with N=3 clears overflow on its start edge.
// - Assert reset in cycle 5 of an N=8 run:
//   - all outputs return to reset values asynchronously; no done pulse.
//   - A fresh start then reproduces the first scenario exactly.
// - start held low with N=2 in a second pulse while busy:
//   - the second request is ignored;
//   - with start held low continuously, runs repeat with a 1-cycle IDLE gap.
// - Change count_InBUS mid-run from 8 to 3: the run still emits 8 terms.

Source files
------------

// File: rtl/sc_fib_sequencer_pkg.sv
// rtl/sc_fib_sequencer_pkg.sv - shared widths and FSM state encoding for the Fibonacci sequencer
package sc_fib_sequencer_pkg;

  // Default widths for emitted terms and for the term count / index
  localparam int FibSEQ_DATAWIDTH_DEFAULT = 8;
  localparam int FibSEQ_CNTWIDTH_DEFAULT  = 5;

  // 3-bit state encoding; the remaining codes are unused and recover to IDLE
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    EMIT  = 3'd2,
    STEP  = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/sc_fib_operand_pair.sv
// rtl/sc_fib_operand_pair.sv - A/B operand registers with truncation flags and the widened adder
module sc_fib_operand_pair
  import sc_fib_sequencer_pkg::*;
#(
  parameter int DATAWIDTH = FibSEQ_DATAWIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init,
  input  logic                 step,
  output logic [DATAWIDTH-1:0] a,
  output logic                 a_ovf
);

  localparam logic [DATAWIDTH-1:0] ONE = {{(DATAWIDTH-1){1'b0}}, 1'b1};

  logic [DATAWIDTH-1:0] b;
  logic                 b_ovf;
  logic [DATAWIDTH:0]   sum;

  // One extra bit so the carry out of the term width is visible as truncation
  assign sum = {1'b0, a} + {1'b0, b};

  // Seed the pair with F0/F1 on init, advance one Fibonacci step on step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a     <= '0;
      b     <= ONE;
      a_ovf <= 1'b0;
      b_ovf <= 1'b0;
    end else if (init) begin
      a     <= '0;
      b     <= ONE;
      a_ovf <= 1'b0;
      b_ovf <= 1'b0;
    end else if (step) begin
      a     <= b;
      a_ovf <= b_ovf;
      b     <= sum[DATAWIDTH-1:0];
      b_ovf <= b_ovf | a_ovf | sum[DATAWIDTH];
    end
  end

endmodule

// File: rtl/sc_fib_sequencer.sv
// rtl/sc_fib_sequencer.sv - start-triggered Fibonacci term generator driving a downstream result register
module sc_fib_sequencer
  import sc_fib_sequencer_pkg::*;
#(
  parameter int FibSEQ_DATAWIDTH = FibSEQ_DATAWIDTH_DEFAULT,
  parameter int FibSEQ_CNTWIDTH  = FibSEQ_CNTWIDTH_DEFAULT
) (
  input  logic                        SC_FibSEQ_CLOCK_50,
  input  logic                        SC_FibSEQ_RESET_InHigh,
  input  logic                        SC_FibSEQ_start_InLow,
  input  logic [FibSEQ_CNTWIDTH-1:0]  SC_FibSEQ_count_InBUS,
  output logic [FibSEQ_DATAWIDTH-1:0] SC_FibSEQ_data_OutBUS,
  output logic                        SC_FibSEQ_clear_OutLow,
  output logic                        SC_FibSEQ_load_OutLow,
  output logic                        SC_FibSEQ_busy_Out,
  output logic                        SC_FibSEQ_done_Out,
  output logic                        SC_FibSEQ_overflow_Out
);

  localparam logic [FibSEQ_CNTWIDTH-1:0] CNT_ONE = {{(FibSEQ_CNTWIDTH-1){1'b0}}, 1'b1};

  state_t                      state;
  logic [FibSEQ_CNTWIDTH-1:0]  k;
  logic [FibSEQ_CNTWIDTH-1:0]  nreg;
  logic                        ovf_sticky;
  logic                        start_accept;
  logic [FibSEQ_DATAWIDTH-1:0] a;
  logic                        a_ovf;

  // A start is only accepted from IDLE; anything while busy is ignored
  assign start_accept = (state == IDLE) && !SC_FibSEQ_start_InLow;

  sc_fib_operand_pair #(
    .DATAWIDTH (FibSEQ_DATAWIDTH)
  ) u_operand_pair (
    .clk   (SC_FibSEQ_CLOCK_50),
    .rst   (SC_FibSEQ_RESET_InHigh),
    .init  (start_accept),
    .step  (state == STEP),
    .a     (a),
    .a_ovf (a_ovf)
  );

  // Run sequencing: latch N on start, alternate EMIT/STEP until N terms are out, then pulse DONE
  always_ff @(posedge SC_FibSEQ_CLOCK_50 or posedge SC_FibSEQ_RESET_InHigh) begin
    if (SC_FibSEQ_RESET_InHigh) begin
      state      <= IDLE;
      k          <= '0;
      nreg       <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_accept) begin
            nreg       <= SC_FibSEQ_count_InBUS;
            k          <= '0;
            ovf_sticky <= 1'b0;
            state      <= CLEAR;
          end
        end
        CLEAR: begin
          state <= (nreg != '0) ? EMIT : DONE;
        end
        EMIT: begin
          if (a_ovf) begin
            ovf_sticky <= 1'b1;
          end
          if (k == nreg - CNT_ONE) begin
            state <= DONE;
          end else begin
            k     <= k + CNT_ONE;
            state <= STEP;
          end
        end
        STEP: begin
          state <= EMIT;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Strobes come only from registered state, so inputs never reach outputs combinationally;
  // overflow includes the term currently on the bus so it rises in the same EMIT cycle
  assign SC_FibSEQ_data_OutBUS  = a;
  assign SC_FibSEQ_clear_OutLow = (state != CLEAR);
  assign SC_FibSEQ_load_OutLow  = (state != EMIT);
  assign SC_FibSEQ_busy_Out     = (state != IDLE);
  assign SC_FibSEQ_done_Out     = (state == DONE);
  assign SC_FibSEQ_overflow_Out = ovf_sticky | ((state == EMIT) & a_ovf);

endmodule
